// File: rtl/seq_mmc_if.sv
// ============================================================================
// Module      : seq_mmc_if
// Description : Start/busy/valid handshake and operand/result bus for seq_mmc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mmc_if #(
  parameter int WIDTH = 8
) ();
  logic                 enb_i;
  logic                 start_i;
  logic [WIDTH-1:0]     dtx_i;
  logic [WIDTH-1:0]     dty_i;
  logic [2*WIDTH-1:0]   dt_o;
  logic                 valid_o;
  logic                 busy_o;

  modport master (
    output enb_i, start_i, dtx_i, dty_i,
    input  dt_o, valid_o, busy_o
  );

  modport slave (
    input  enb_i, start_i, dtx_i, dty_i,
    output dt_o, valid_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/seq_mmc.sv
// ============================================================================
// Module      : seq_mmc
// Description : Multicycle LCM engine: subtractive GCD, subtractive divide,
//               then shift-add multiply, lcm = (x / gcd) * y.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mmc #(
  parameter int WIDTH = 8
) (
  input  wire logic  clk_i,
  input  wire logic  rstn_i,
  seq_mmc_if.slave   bus
);

  localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [WIDTH-1:0]   c_q_one    = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GCD  = 3'd1,
    S_DIV  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_a, r_b, r_x, r_y, r_g, r_r, r_q, r_mplier;
  logic [WIDTH-1:0]     w_a, w_b, w_x, w_y, w_g, w_r, w_q, w_mplier;
  logic [2*WIDTH-1:0]   r_mcand, r_p, r_dt;
  logic [2*WIDTH-1:0]   w_mcand, w_p, w_dt, w_sum;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt;
  logic                 r_valid, r_busy, w_valid, w_busy;

  assign w_sum = r_p + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_state_next = r_state;
    w_a      = r_a;
    w_b      = r_b;
    w_x      = r_x;
    w_y      = r_y;
    w_g      = r_g;
    w_r      = r_r;
    w_q      = r_q;
    w_mplier = r_mplier;
    w_mcand  = r_mcand;
    w_p      = r_p;
    w_cnt    = r_cnt;
    w_dt     = r_dt;
    w_valid  = 1'b0;
    w_busy   = r_busy;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_x    = bus.dtx_i;
          w_y    = bus.dty_i;
          w_a    = bus.dtx_i;
          w_b    = bus.dty_i;
          w_busy = 1'b1;
          if (bus.dtx_i == '0 || bus.dty_i == '0) begin
            w_p          = '0;
            w_dt         = '0;
            w_valid      = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_GCD;
          end
        end
      end
      S_GCD: begin
        if (r_a == r_b) begin
          w_g          = r_a;
          w_r          = r_x;
          w_q          = '0;
          w_state_next = S_DIV;
        end else if (r_a > r_b) begin
          w_a = r_a - r_b;
        end else begin
          w_b = r_b - r_a;
        end
      end
      S_DIV: begin
        // g divides x, so the remainder always lands on zero
        if (r_r >= r_g) begin
          w_r = r_r - r_g;
          w_q = r_q + c_q_one;
        end else begin
          w_mcand      = {{WIDTH{1'b0}}, r_y};
          w_mplier     = r_q;
          w_p          = '0;
          w_cnt        = '0;
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        w_p      = w_sum;
        w_mcand  = r_mcand << 1;
        w_mplier = r_mplier >> 1;
        w_cnt    = r_cnt + c_cnt_one;
        // result and pulse are registered on entry so they are visible in DONE
        if (r_cnt == c_cnt_last) begin
          w_dt         = w_sum;
          w_valid      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_g      <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_dt     <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (bus.enb_i) begin
      r_state  <= w_state_next;
      r_a      <= w_a;
      r_b      <= w_b;
      r_x      <= w_x;
      r_y      <= w_y;
      r_g      <= w_g;
      r_r      <= w_r;
      r_q      <= w_q;
      r_mplier <= w_mplier;
      r_mcand  <= w_mcand;
      r_p      <= w_p;
      r_cnt    <= w_cnt;
      r_dt     <= w_dt;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
    end
  end

  assign bus.dt_o    = r_dt;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = r_busy;

endmodule

`default_nettype wire
